// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU between two requesters.
// state | meaning: IDLE wait for req | EXEC ALU inputs stable | CAPT capture alu_y | RESP hold response until owner ready
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic [1:0]        gnt,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_y,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic [1:0]        r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic [DATA_W-1:0] r_alu_a, w_alu_a_nxt;
  logic [DATA_W-1:0] r_alu_b, w_alu_b_nxt;
  logic [1:0]        r_alu_sel, w_alu_sel_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_rr_last, w_rr_last_nxt;
  logic              w_win;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    if (req == 2'b01)      w_win = 1'b0;
    else if (req == 2'b10) w_win = 1'b1;
    else                   w_win = ~r_rr_last;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = 2'b00;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_alu_sel_nxt   = r_alu_sel;
    w_owner_nxt     = r_owner;
    w_rr_last_nxt   = r_rr_last;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_state_nxt   = EXEC;
          w_alu_a_nxt   = w_win ? req1_a  : req0_a;
          w_alu_b_nxt   = w_win ? req1_b  : req0_b;
          w_alu_sel_nxt = w_win ? req1_op : req0_op;
          w_gnt_nxt     = w_win ? 2'b10   : 2'b01;
          w_owner_nxt   = w_win;
          w_rr_last_nxt = w_win;
        end
      end
      EXEC: w_state_nxt = CAPT;
      CAPT: begin
        w_rsp_data_nxt  = alu_y;
        w_rsp_valid_nxt = r_owner ? 2'b10 : 2'b01;
        w_state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_ready[r_owner]) begin
          w_rsp_valid_nxt = 2'b00;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= 2'b00;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= 2'b00;
      r_owner     <= 1'b0;
      r_rr_last   <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_alu_sel   <= w_alu_sel_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_last   <= w_rr_last_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the registered ALU, replays directed vectors,
// corner sequences and a randomized run against a transaction-level model.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, req0_op, req1_op, rsp_ready, gnt, rsp_valid, alu_sel;
  logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp_data, alu_a, alu_b, alu_y;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int model_last = 1;

  alu_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'd0:    alu_fn = a + b;
      2'd1:    alu_fn = a - b;
      2'd2:    alu_fn = {a[6:0], 1'b0};
      default: alu_fn = (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk) alu_y <= alu_fn(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in an IDLE cycle; req is sampled at the next edge.
  task automatic do_txn(input logic [1:0] r, input int w, input logic [7:0] exp_d,
                        input int delay, input logic noise, input logic keep, input logic wd);
    logic [1:0] own, oth;
    own = (w == 1) ? 2'b10 : 2'b01;
    oth = ~own;
    req = r;
    tick();
    chk("gnt", 32'(gnt), 32'(own));
    chk("busy_exec", 32'(busy), 32'd1);
    chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
    model_last = w;
    if (wd) req = oth;
    else if (!keep) req = req & ~own;
    tick();
    if (wd) req = 2'b00;
    chk("gnt_pulse", 32'(gnt), 32'd0);
    chk("rsp_valid_capt", 32'(rsp_valid), 32'd0);
    if (!keep) begin
      if (w == 1) begin req1_a = 8'($urandom); req1_b = 8'($urandom); end
      else begin req0_a = 8'($urandom); req0_b = 8'($urandom); end
    end
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'(own));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    for (int d = 0; d < delay; d++) begin
      rsp_ready = noise ? oth : 2'b00;
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'(own));
      chk("hold_data", 32'(rsp_data), 32'(exp_d));
      chk("hold_gnt", 32'(gnt), 32'd0);
    end
    rsp_ready = own | (noise ? oth : 2'b00);
    tick();
    rsp_ready = 2'b00;
    chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
  endtask

  typedef struct {
    logic [1:0] r;
    logic [7:0] a0, b0; logic [1:0] op0;
    logic [7:0] a1, b1; logic [1:0] op1;
    logic       keep;
    int         delay;
    int         exp_w;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic p0, p1;
    logic [1:0] r;
    int w;
    logic [7:0] e;

    vecs[0]  = '{2'b01, 8'd5,   8'd3, 2'd0, 8'd0,   8'd0,   2'd0, 1'b0, 0, 0, 8'd8};
    vecs[1]  = '{2'b11, 8'd10,  8'd4, 2'd1, 8'd7,   8'd7,   2'd3, 1'b1, 0, 1, 8'd1};
    vecs[2]  = '{2'b11, 8'd10,  8'd4, 2'd1, 8'd7,   8'd7,   2'd3, 1'b1, 0, 0, 8'd6};
    vecs[3]  = '{2'b11, 8'd10,  8'd4, 2'd1, 8'd7,   8'd7,   2'd3, 1'b1, 1, 1, 8'd1};
    vecs[4]  = '{2'b11, 8'd10,  8'd4, 2'd1, 8'd7,   8'd7,   2'd3, 1'b1, 0, 0, 8'd6};
    vecs[5]  = '{2'b10, 8'd0,   8'd0, 2'd0, 8'd200, 8'd100, 2'd0, 1'b0, 0, 1, 8'd44};
    vecs[6]  = '{2'b10, 8'd0,   8'd0, 2'd0, 8'h81,  8'd0,   2'd2, 1'b0, 2, 1, 8'h02};
    vecs[7]  = '{2'b11, 8'hFF,  8'd1, 2'd0, 8'd3,   8'd5,   2'd1, 1'b0, 0, 0, 8'h00};
    vecs[8]  = '{2'b10, 8'd0,   8'd0, 2'd0, 8'd3,   8'd5,   2'd1, 1'b0, 0, 1, 8'hFE};
    vecs[9]  = '{2'b01, 8'd9,   8'd9, 2'd3, 8'd0,   8'd0,   2'd0, 1'b0, 0, 0, 8'd1};
    vecs[10] = '{2'b01, 8'd9,   8'd8, 2'd3, 8'd0,   8'd0,   2'd0, 1'b0, 0, 0, 8'd0};

    rst_n = 1'b0; req = 2'b00; rsp_ready = 2'b00;
    req0_a = 8'd0; req0_b = 8'd0; req0_op = 2'd0;
    req1_a = 8'd0; req1_b = 8'd0; req1_op = 2'd0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    model_last = 1;
    tick();

    for (int i = 0; i < 11; i++) begin
      req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_op = vecs[i].op0;
      req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_op = vecs[i].op1;
      do_txn(vecs[i].r, vecs[i].exp_w, vecs[i].exp_d, vecs[i].delay, 1'b1, vecs[i].keep, 1'b0);
    end
    req = 2'b00;
    tick();

    // Backpressure with req0 still requesting: no grant until the response is taken.
    req0_a = 8'd5; req0_b = 8'd3; req0_op = 2'd0;
    do_txn(2'b01, 0, 8'd8, 5, 1'b1, 1'b1, 1'b0);
    do_txn(2'b01, 0, 8'd8, 0, 1'b0, 1'b0, 1'b0);

    // Reset during CAPT drops the operation and restores the tie-break.
    req0_a = 8'd5; req0_b = 8'd3; req0_op = 2'd1;
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
    chk("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    model_last = 1;
    req0_a = 8'd1; req0_b = 8'd2; req0_op = 2'd0;
    req1_a = 8'd4; req1_b = 8'd4; req1_op = 2'd3;
    do_txn(2'b11, 0, 8'd3, 0, 1'b0, 1'b0, 1'b0);
    do_txn(2'b10, 1, 8'd1, 0, 1'b0, 1'b0, 1'b0);

    // A one-cycle request from requester 1 while busy must not be remembered.
    req0_a = 8'd20; req0_b = 8'd7; req0_op = 2'd1;
    do_txn(2'b01, 0, 8'd13, 1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("withdraw_gnt", 32'(gnt), 32'd0);
      chk("withdraw_busy", 32'(busy), 32'd0);
    end

    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!p0 && $urandom_range(1) == 1) begin
        p0 = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
      end
      if (!p1 && $urandom_range(1) == 1) begin
        p1 = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
      end
      if (!p0 && !p1) begin
        p0 = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
      end
      r = {p1, p0};
      if (r == 2'b11) w = 1 - model_last;
      else w = (r == 2'b10) ? 1 : 0;
      e = (w == 1) ? alu_fn(req1_a, req1_b, req1_op) : alu_fn(req0_a, req0_b, req0_op);
      do_txn(r, w, e, $urandom_range(3), 1'($urandom_range(1)), 1'b0, 1'b0);
      if (w == 1) p1 = 1'b0;
      else p0 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit registered ALU between two requesters (e.g. instruction executor and address/loop unit).
- Drives the ALU operand and select inputs and sequences its one-cycle registered latency.
- Captures the ALU result and returns it to the winning requester over a valid/ready response channel.
- Round-robin arbitration. One operation in flight at a time.

Parameters:
- DATA_W, 8, operand/result width; must equal ALU width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester operation request; bit i = requester i.
- req0_a  in  DATA_W  requester 0 operand A.
- req0_b  in  DATA_W  requester 0 operand B.
- req0_op  in  2  requester 0 ALU select: 00 add, 01 sub, 10 shl A, 11 compare-equal.
- req1_a  in  DATA_W  requester 1 operand A.
- req1_b  in  DATA_W  requester 1 operand B.
- req1_op  in  2  requester 1 ALU select.
- gnt  out  2  one-cycle pulse; operands of requester i accepted.
- rsp_valid  out  2  result available for requester i.
- rsp_ready  in  2  requester i accepts result.
- rsp_data  out  DATA_W  result, shared by both requesters, qualified by rsp_valid.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_sel  out  2  to ALU sel.
- alu_y  in  DATA_W  from ALU Y (registered inside ALU).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - gnt, rsp_valid, rsp_data, alu_a, alu_b, alu_sel = 0.
  - rr_last=1, so requester 0 wins the first tie.
  - Any in-flight operation or pending response is discarded.
- States: IDLE, EXEC, CAPT, RESP. All outputs are registered.
- IDLE:
  - If req != 0, pick the winner w.
    - Only one bit set: that requester.
    - Both set: requester != rr_last.
  - At the clock edge:
    - alu_a/alu_b/alu_sel <= operands of w.
    - gnt[w] <= 1 for one cycle.
    - owner <= w; rr_last <= w.
    - state <= EXEC.
  - req == 0: stay in IDLE; ALU inputs hold their last values.
- EXEC:
  - ALU inputs are stable; the ALU samples them on the edge leaving EXEC.
  - gnt returns to 0.
  - Next state: CAPT.
- CAPT:
  - alu_y now holds the result. rsp_data <= alu_y.
  - rsp_valid[owner] <= 1.
  - Next state: RESP.
- RESP:
  - Hold rsp_data and rsp_valid[owner] stable until rsp_ready[owner]=1.
  - On that edge: rsp_valid <= 0, state <= IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency:
  - req sampled in IDLE at cycle T.
  - gnt high in T+1.
  - rsp_valid high from T+3.
  - With rsp_ready held high, the next grant can occur no earlier than T+5 (IDLE at T+4).
- Requester contract:
  - Hold req and operands stable until gnt.
  - Operands may change from the cycle after gnt.
  - Dropping req before gnt withdraws the request; no grant is issued.
  - req asserted while busy waits for IDLE. It is not queued beyond the live req level.
- Arithmetic: performed by the ALU; the arbiter passes the result through unmodified.
  - add/sub wrap modulo 2^DATA_W.
  - shl discards the MSB.
  - compare returns 1 or 0, zero-extended.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1…
- Simultaneous events: none possible within a transaction, since only one transaction runs at a time.
- Reset mid-operation: the state machine returns immediately to IDLE and the response is lost. The ALU's own Y is not cleared by this block.

Test Plan:
1. Reset, then req=01, req0 a=5 b=3 op=00 -> gnt=01 at T+1; rsp_valid=01, rsp_data=8 at T+3; rsp_ready=01 -> rsp_valid=00, busy=0 next cycle.
2. req=11 held continuously, req0 op=01 a=10 b=4, req1 op=11 a=7 b=7, rsp_ready=11 -> grants alternate 01,10,01; rsp_data alternates 6, 1, 6.
3. req1 a=200 b=100 op=00 -> rsp_data=44 (wrap); then a=0x81 op=10 -> rsp_data=0x02.
4. Backpressure: result 8 ready, rsp_ready=00 for 5 cycles -> rsp_valid and rsp_data=8 held; meanwhile req0 held high -> no gnt until rsp_ready=01 and return to IDLE.
5. Reset mid-op: assert rst_n=0 during CAPT -> all outputs 0 asynchronously; after release, req=11 -> gnt=01 first.
6. Withdraw: req=10 pulsed for one cycle while busy, then dropped -> no gnt to requester 1 ever issued.
